// File: rtl/seq_restoring_divider.sv
// Purpose: unsigned restoring divider, one trial subtraction per clock, start/done handshake.
// Latency: WIDTH+1 cycles from accepting edge to done (1 cycle when divisor is zero).
// Backpressure: start is ignored while an operation runs; a start in the FIN cycle is accepted.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dvs_q;     // latched divisor
    logic [WIDTH-1:0] rem_q;     // partial remainder; always < divisor so WIDTH bits hold it
    logic [WIDTH-1:0] quo_q;     // dividend shifts out the top, quotient bits shift in
    logic [CW-1:0]    step_q;
    logic             dz_q;      // result being assembled is a divide-by-zero

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             accept;

    // Shift next dividend bit into the remainder and try subtracting the divisor;
    // the top bit of the WIDTH+1-bit difference is the borrow.
    assign trial  = {rem_q, quo_q[WIDTH-1]};
    assign diff   = trial + {1'b1, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
    assign accept = start && ((state == S_IDLE) || (state == S_FIN));

    // Control FSM, datapath and registered outputs; outputs lag state by one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            step_q      <= '0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state == S_RUN);
            done <= (state == S_FIN);
            if (state == S_FIN) begin
                quotient    <= quo_q;
                remainder   <= rem_q;
                div_by_zero <= dz_q;
            end

            case (state)
                S_IDLE, S_FIN: begin
                    if (accept) begin
                        if (divisor != '0) begin
                            dvs_q  <= divisor;
                            rem_q  <= '0;
                            quo_q  <= dividend;
                            step_q <= '0;
                            dz_q   <= 1'b0;
                            state  <= S_RUN;
                        end else begin
                            // Divide-by-zero skips iteration: quotient saturates, dividend passes through.
                            rem_q <= dividend;
                            quo_q <= '1;
                            dz_q  <= 1'b1;
                            state <= S_FIN;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (!diff[WIDTH]) begin
                        rem_q <= diff[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    step_q <= step_q + CW'(1);
                    if (step_q == LAST_STEP) begin
                        state <= S_FIN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Purpose: directed checks of the WIDTH=4 restoring divider plus a full operand sweep.
// Latency: expects done WIDTH+1 edges after a nonzero-divisor start, 1 edge for divide-by-zero.
// Backpressure: exercises ignored start while running and back-to-back start in FIN.
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_restoring_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int a, input int b);
        start    = 1'b1;
        dividend = 4'(a);
        divisor  = 4'(b);
        tick();
        start    = 1'b0;
    endtask

    // Start an op, wait (bounded) for done, check latency and results.
    task automatic run_op(input string tag, input int a, input int b,
                          input int eq, input int er, input int edz, input int elat);
        int n;
        n = 0;
        do_start(a, b);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        chk({tag, " latency"}, n, elat);
        chk({tag, " q"}, quotient, eq);
        chk({tag, " r"}, remainder, er);
        chk({tag, " dz"}, div_by_zero, edz);
        chk({tag, " busy@done"}, busy, 0);
    endtask

    initial begin
        int pulses;
        int pq;
        int pr;
        int eq;
        int er;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        tick();
        tick();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset q", quotient, 0);
        chk("reset r", remainder, 0);
        chk("reset dz", div_by_zero, 0);
        rst_n = 1'b1;
        tick();

        // 13/4 with cycle-by-cycle busy/done timing
        do_start(13, 4);
        chk("13/4 busy after edge0", busy, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("13/4 busy edge%0d", k), busy, 1);
            chk($sformatf("13/4 done edge%0d", k), done, 0);
        end
        tick();
        chk("13/4 done edge5", done, 1);
        chk("13/4 busy edge5", busy, 0);
        chk("13/4 q", quotient, 3);
        chk("13/4 r", remainder, 1);
        chk("13/4 dz", div_by_zero, 0);
        tick();
        chk("13/4 done single", done, 0);
        chk("13/4 q held", quotient, 3);
        chk("13/4 r held", remainder, 1);

        // Boundaries
        run_op("15/1", 15, 1, 15, 0, 0, 5);
        run_op("3/7", 3, 7, 0, 3, 0, 5);
        run_op("0/5", 0, 5, 0, 0, 0, 5);
        run_op("15/15", 15, 15, 1, 0, 0, 5);

        // Divide by zero, then a normal op clears the flag
        run_op("9/0", 9, 0, 15, 9, 1, 1);
        run_op("6/3", 6, 3, 2, 0, 0, 5);

        // Start while busy is ignored
        do_start(13, 4);
        tick();
        start    = 1'b1;
        dividend = 4'd2;
        divisor  = 4'd1;
        tick();
        start    = 1'b0;
        pulses = 0;
        pq = 0;
        pr = 0;
        for (int i = 3; i <= 14; i++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                pq = int'(quotient);
                pr = int'(remainder);
                chk("ignore done edge", i, 5);
            end
        end
        chk("ignore pulses", pulses, 1);
        chk("ignore q", pq, 3);
        chk("ignore r", pr, 1);

        // Back-to-back: start held through the FIN cycle
        do_start(14, 3);
        for (int k = 1; k <= 4; k++) tick();
        chk("b2b fin busy", busy, 1);
        chk("b2b fin done", done, 0);
        start    = 1'b1;
        dividend = 4'd8;
        divisor  = 4'd2;
        tick();
        start    = 1'b0;
        chk("b2b first done", done, 1);
        chk("b2b first q", quotient, 4);
        chk("b2b first r", remainder, 2);
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                chk("b2b second spacing", i, 5);
                chk("b2b second q", quotient, 4);
                chk("b2b second r", remainder, 0);
            end
        end
        chk("b2b second pulses", pulses, 1);

        // Reset mid-operation abandons the op
        do_start(13, 4);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst q", quotient, 0);
        chk("midrst r", remainder, 0);
        chk("midrst dz", div_by_zero, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk("midrst no done", pulses, 0);
        chk("midrst idle busy", busy, 0);

        // Full operand sweep against a reference model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 15;
                    er = a;
                end else begin
                    eq = a / b;
                    er = a % b;
                end
                run_op($sformatf("sweep %0d/%0d", a, b), a, b, eq, er, (b == 0) ? 1 : 0, (b == 0) ? 1 : 5);
                if (b != 0) begin
                    chk($sformatf("sweep inv %0d/%0d", a, b),
                        int'(quotient) * b + int'(remainder), a);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
